// File: rtl/cicles_window_gen.sv
// Cycle-window generator: emits enable_out for exactly cycles_req counted falling edges, pausable by hold.
// Optional macro CICLES_WINDOW_REPEAT_EN adds the repeat_en input for back-to-back auto-reloaded windows.
module cicles_window_gen #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] cycles_req,
   input  logic             hold,
   input  logic             abort,
`ifdef CICLES_WINDOW_REPEAT_EN
   input  logic             repeat_en,
`endif
   output logic             enable_out,
   output logic [WIDTH-1:0] remaining,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] remaining_q, remaining_d;
   logic [WIDTH-1:0] req_q, req_d;
   logic             rep_pulse_q, rep_pulse_d;
   logic             rep_req;

`ifdef CICLES_WINDOW_REPEAT_EN
   assign rep_req = repeat_en;
`else
   assign rep_req = 1'b0;
`endif

   // State update on the falling edge, matching the counters this block feeds.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         req_q       <= '0;
         rep_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         req_q       <= req_d;
         rep_pulse_q <= rep_pulse_d;
      end
   end

   // Next-state, count and strobe decode.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      req_d       = req_q;
      rep_pulse_d = 1'b0;
      enable_out  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if (cycles_req != '0) begin
                  remaining_d = cycles_req;
                  req_d       = cycles_req;
                  state_d     = RUN;
               end else begin
                  state_d = DONE;
               end
            end
         end

         RUN: begin
            if (abort) begin
               remaining_d = '0;
               state_d     = IDLE;
            end else if (!hold) begin
               enable_out = 1'b1;
               // Final counted edge: reload for another window or finish; never wraps below zero.
               if (remaining_q <= WIDTH'(1)) begin
                  if (rep_req) begin
                     remaining_d = req_q;
                     rep_pulse_d = 1'b1;
                  end else begin
                     remaining_d = '0;
                     state_d     = DONE;
                  end
               end else begin
                  remaining_d = remaining_q - WIDTH'(1);
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign remaining = remaining_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE) | rep_pulse_q;

endmodule

// File: tb/tb_cicles_window_gen.sv
// Self-checking bench for cicles_window_gen: a model downstream counter plus a scoreboard of expected windows.
// Define CICLES_WINDOW_REPEAT_EN to also exercise the repeat feature.
module tb_cicles_window_gen;

   localparam int unsigned WIDTH = 8;

   logic             clk;
   logic             reset;
   logic             start;
   logic [WIDTH-1:0] cycles_req;
   logic             hold;
   logic             abort;
`ifdef CICLES_WINDOW_REPEAT_EN
   logic             repeat_en;
`endif
   logic             enable_out;
   logic [WIDTH-1:0] remaining;
   logic             busy;
   logic             done;

   typedef struct {
      int count;
      int dones;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   ds_count;
   int   done_cnt;

   cicles_window_gen #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .cycles_req (cycles_req),
      .hold       (hold),
      .abort      (abort),
`ifdef CICLES_WINDOW_REPEAT_EN
      .repeat_en  (repeat_en),
`endif
      .enable_out (enable_out),
      .remaining  (remaining),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream counter: counts falling edges seen with enable_out high.
   initial ds_count = 0;
   always @(negedge clk) if (!reset && enable_out) ds_count <= ds_count + 1;

   initial done_cnt = 0;
   always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic wait_idle(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy && !done) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, expected 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b, expected 0", done); end
      checks++; if (enable_out !== 1'b0) begin errors++; $display("FAIL reset_enable: got %0b, expected 0", enable_out); end
      checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining: got %0d, expected 0", remaining); end
      reset = 1'b0;
      @(posedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %0b, expected 0", busy); end
   endtask

   task automatic test_basic();
      int   bc, bd;
      bit   ok;
      exp_t e;
      sb.push_back('{5, 1});
      bc = ds_count; bd = done_cnt;
      start = 1'b1; cycles_req = 8'd5;
      @(posedge clk);
      start = 1'b0;
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %0b, expected 1", busy); end
      checks++; if (remaining !== 8'd5) begin errors++; $display("FAIL basic_latch: got %0d, expected 5", remaining); end
      checks++; if (enable_out !== 1'b1) begin errors++; $display("FAIL basic_enable: got %0b, expected 1", enable_out); end
      wait_idle(50, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_timeout: got busy, expected idle within 50 cycles"); end
      e = sb.pop_front();
      checks++; if (ds_count - bc !== e.count) begin errors++; $display("FAIL basic_count: got %0d, expected %0d", ds_count - bc, e.count); end
      checks++; if (done_cnt - bd !== e.dones) begin errors++; $display("FAIL basic_done: got %0d, expected %0d", done_cnt - bd, e.dones); end
      checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL basic_rem_end: got %0d, expected 0", remaining); end
   endtask

   task automatic test_hold();
      int         bc, bd, c, busy_cyc;
      bit         ok;
      logic [7:0] rem_prev;
      exp_t       e;
      sb.push_back('{10, 1});
      bc = ds_count; bd = done_cnt;
      start = 1'b1; cycles_req = 8'd10;
      @(posedge clk);
      start = 1'b0;
      c = 1; busy_cyc = 0; ok = 1'b0; rem_prev = '0;
      while (c < 60) begin
         if (!busy && !done) begin ok = 1'b1; break; end
         if (busy) busy_cyc++;
         if (c >= 5 && c <= 7) begin
            checks++; if (remaining !== rem_prev) begin errors++; $display("FAIL hold_frozen c=%0d: got %0d, expected %0d", c, remaining, rem_prev); end
            checks++; if (enable_out !== 1'b0) begin errors++; $display("FAIL hold_gate c=%0d: got %0b, expected 0", c, enable_out); end
         end
         hold = (c >= 4 && c <= 6);
         rem_prev = remaining;
         @(posedge clk);
         c++;
      end
      hold = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL hold_timeout: got busy, expected idle within 60 cycles"); end
      checks++; if (busy_cyc !== 13) begin errors++; $display("FAIL hold_len: got %0d, expected 13", busy_cyc); end
      e = sb.pop_front();
      checks++; if (ds_count - bc !== e.count) begin errors++; $display("FAIL hold_count: got %0d, expected %0d", ds_count - bc, e.count); end
      checks++; if (done_cnt - bd !== e.dones) begin errors++; $display("FAIL hold_done: got %0d, expected %0d", done_cnt - bd, e.dones); end
   endtask

   task automatic test_abort();
      int   ab_at [2] = '{4, 8};
      int   bc, bd;
      exp_t e;
      for (int t = 0; t < 2; t++) begin
         sb.push_back('{ab_at[t] - 1, 0});
         bc = ds_count; bd = done_cnt;
         start = 1'b1; cycles_req = 8'd8;
         @(posedge clk);
         start = 1'b0;
         for (int c = 1; c < ab_at[t]; c++) @(posedge clk);
         checks++; if (remaining !== 8'(9 - ab_at[t])) begin errors++; $display("FAIL abort_pre_rem%0d: got %0d, expected %0d", t, remaining, 9 - ab_at[t]); end
         abort = 1'b1;
         @(posedge clk);
         abort = 1'b0;
         checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy%0d: got %0b, expected 0", t, busy); end
         checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL abort_rem%0d: got %0d, expected 0", t, remaining); end
         repeat (3) @(posedge clk);
         e = sb.pop_front();
         checks++; if (ds_count - bc !== e.count) begin errors++; $display("FAIL abort_count%0d: got %0d, expected %0d", t, ds_count - bc, e.count); end
         checks++; if (done_cnt - bd !== e.dones) begin errors++; $display("FAIL abort_done%0d: got %0d, expected %0d", t, done_cnt - bd, e.dones); end
      end
   endtask

   task automatic test_zero();
      int   bc, bd;
      bit   ok;
      exp_t e;
      sb.push_back('{0, 1});
      bc = ds_count; bd = done_cnt;
      start = 1'b1; cycles_req = 8'd0;
      @(posedge clk);
      start = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done_now: got %0b, expected 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy: got %0b, expected 0", busy); end
      wait_idle(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: got busy, expected idle within 10 cycles"); end
      e = sb.pop_front();
      checks++; if (ds_count - bc !== e.count) begin errors++; $display("FAIL zero_count: got %0d, expected %0d", ds_count - bc, e.count); end
      checks++; if (done_cnt - bd !== e.dones) begin errors++; $display("FAIL zero_dones: got %0d, expected %0d", done_cnt - bd, e.dones); end
   endtask

   task automatic test_max();
      int   bc, bd;
      bit   ok;
      exp_t e;
      sb.push_back('{255, 1});
      bc = ds_count; bd = done_cnt;
      start = 1'b1; cycles_req = 8'd255;
      @(posedge clk);
      start = 1'b0;
      wait_idle(300, ok);
      checks++; if (!ok) begin errors++; $display("FAIL max_timeout: got busy, expected idle within 300 cycles"); end
      e = sb.pop_front();
      checks++; if (ds_count - bc !== e.count) begin errors++; $display("FAIL max_count: got %0d, expected %0d", ds_count - bc, e.count); end
      checks++; if (done_cnt - bd !== e.dones) begin errors++; $display("FAIL max_done: got %0d, expected %0d", done_cnt - bd, e.dones); end
      checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL max_rem: got %0d, expected 0", remaining); end
   endtask

   task automatic test_async_reset();
      int bd;
      bd = done_cnt;
      start = 1'b1; cycles_req = 8'd8;
      @(posedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      checks++; if (remaining !== 8'd4) begin errors++; $display("FAIL areset_pre: got %0d, expected 4", remaining); end
      #2 reset = 1'b1;
      #1;
      checks++; if (enable_out !== 1'b0) begin errors++; $display("FAIL areset_enable: got %0b, expected 0", enable_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_busy: got %0b, expected 0", busy); end
      checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL areset_rem: got %0d, expected 0", remaining); end
      #1 reset = 1'b0;
      repeat (3) @(posedge clk);
      checks++; if (done_cnt - bd !== 0) begin errors++; $display("FAIL areset_nodone: got %0d, expected 0", done_cnt - bd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL areset_idle: got %0b, expected 0", busy); end
   endtask

   task automatic test_start_ignored();
      int   bc, bd;
      bit   seen;
      exp_t e;
      sb.push_back('{3, 1});
      bc = ds_count; bd = done_cnt;
      start = 1'b1; cycles_req = 8'd3;
      @(posedge clk);
      cycles_req = 8'd9;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (done) begin seen = 1'b1; break; end
         @(posedge clk);
      end
      checks++; if (!seen) begin errors++; $display("FAIL ign_timeout: got no done, expected done within 20 cycles"); end
      @(posedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_start: got busy=%0b, expected 0", busy); end
      start = 1'b0;
      repeat (2) @(posedge clk);
      e = sb.pop_front();
      checks++; if (ds_count - bc !== e.count) begin errors++; $display("FAIL ign_count: got %0d, expected %0d", ds_count - bc, e.count); end
      checks++; if (done_cnt - bd !== e.dones) begin errors++; $display("FAIL ign_done: got %0d, expected %0d", done_cnt - bd, e.dones); end
   endtask

`ifdef CICLES_WINDOW_REPEAT_EN
   task automatic test_repeat();
      int   bc, bd;
      bit   ok;
      exp_t e;
      sb.push_back('{12, 3});
      bc = ds_count; bd = done_cnt;
      repeat_en = 1'b1;
      start = 1'b1; cycles_req = 8'd4;
      @(posedge clk);
      start = 1'b0;
      for (int c = 1; c <= 12; c++) begin
         checks++; if (enable_out !== 1'b1) begin errors++; $display("FAIL rep_enable c=%0d: got %0b, expected 1", c, enable_out); end
         repeat_en = (c <= 8);
         @(posedge clk);
      end
      repeat_en = 1'b0;
      wait_idle(10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rep_timeout: got busy, expected idle within 10 cycles"); end
      e = sb.pop_front();
      checks++; if (ds_count - bc !== e.count) begin errors++; $display("FAIL rep_count: got %0d, expected %0d", ds_count - bc, e.count); end
      checks++; if (done_cnt - bd !== e.dones) begin errors++; $display("FAIL rep_done: got %0d, expected %0d", done_cnt - bd, e.dones); end
   endtask
`endif

   initial begin
      checks = 0; errors = 0;
      reset = 1'b1; start = 1'b0; cycles_req = '0; hold = 1'b0; abort = 1'b0;
`ifdef CICLES_WINDOW_REPEAT_EN
      repeat_en = 1'b0;
`endif
      test_reset();
      test_basic();
      test_hold();
      test_abort();
      test_zero();
      test_max();
      test_async_reset();
      test_start_ignored();
`ifdef CICLES_WINDOW_REPEAT_EN
      test_repeat();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
